// File: rtl/acq_sequencer.sv
// Acquisition sequencer: runs one pulse-echo shot (SPRAM capture addressing,
// pulser windows, linear TGC ramp to the gain DAC) and arbitrates the SPRAM address.
module acq_sequencer #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TGC_W  = 10
) (
  input  logic              DCLK,
  input  logic              rst,
  input  logic              trig,
  input  logic [7:0]        phv_start,
  input  logic [7:0]        phv_end,
  input  logic [7:0]        pnhv_start,
  input  logic [7:0]        pnhv_end,
  input  logic [7:0]        damp_start,
  input  logic [7:0]        damp_end,
  input  logic [TGC_W-1:0]  tgc_start,
  input  logic [7:0]        tgc_slope,
  input  logic [7:0]        tgc_interval,
  input  logic              dac_busy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic              PHV,
  output logic              PnHV,
  output logic              Pdamp,
  output logic [TGC_W-1:0]  dac_code,
  output logic              dac_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned       CW        = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [TGC_W:0]    CODE_MAX  = {1'b0, {TGC_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, FINISH} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_tgc_cnt;
  logic [TGC_W-1:0]  r_dac_code;
  logic              r_dac_valid;
  logic              r_dac_pend;
  logic              r_rd_valid;
  logic              r_overrun;
  logic              r_phv;
  logic              r_pnhv;
  logic              r_pdamp;
  logic              w_start;
  logic              w_capture;
  logic              w_step;
  logic              w_load;
  logic [TGC_W:0]    w_sum;
  logic [TGC_W-1:0]  w_code_step;

  function automatic logic in_win(input logic [ADDR_W-1:0] a,
                                  input logic [7:0] s, input logic [7:0] e);
    return (CW'(a) >= CW'(s)) && (CW'(a) < CW'(e));
  endfunction

  always_ff @(posedge DCLK) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    wr_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (trig) begin
          w_start      = 1'b1;
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (r_wr_addr == LAST_ADDR) w_state_next = FINISH;
      end
      FINISH: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (rst || w_start)         r_wr_addr <= '0;
    else if (r_state == CAPTURE) r_wr_addr <= r_wr_addr + ADDR_W'(1);
  end

  // Pulser registers look one cycle ahead so they drop together with the last write.
  assign w_capture = (r_state == CAPTURE) && (w_state_next == CAPTURE);

  always_ff @(posedge DCLK) begin
    if (rst) begin
      r_phv   <= 1'b0;
      r_pnhv  <= 1'b0;
      r_pdamp <= 1'b0;
    end else begin
      r_phv   <= w_capture && in_win(r_wr_addr, phv_start, phv_end);
      r_pnhv  <= w_capture && in_win(r_wr_addr, pnhv_start, pnhv_end);
      r_pdamp <= w_capture && in_win(r_wr_addr, damp_start, damp_end);
    end
  end

  assign w_step      = (r_state == CAPTURE) && (tgc_interval != '0) &&
                       (r_tgc_cnt == tgc_interval - 8'd1);
  assign w_sum       = {1'b0, r_dac_code} + (TGC_W+1)'(tgc_slope);
  assign w_code_step = (w_sum > CODE_MAX) ? '1 : w_sum[TGC_W-1:0];
  assign w_load      = w_start || (w_step && (w_code_step != r_dac_code));

  always_ff @(posedge DCLK) begin
    if (rst || w_start) begin
      r_tgc_cnt <= '0;
    end else if ((r_state == CAPTURE) && (tgc_interval != '0)) begin
      r_tgc_cnt <= w_step ? '0 : r_tgc_cnt + 8'd1;
    end
  end

  always_ff @(posedge DCLK) begin
    if (rst)         r_dac_code <= '0;
    else if (w_start) r_dac_code <= tgc_start;
    else if (w_step)  r_dac_code <= w_code_step;
  end

  // A busy DAC leaves one pending load that always carries the newest code.
  always_ff @(posedge DCLK) begin
    if (rst) begin
      r_dac_valid <= 1'b0;
      r_dac_pend  <= 1'b0;
    end else if (w_load) begin
      r_dac_valid <= !dac_busy;
      r_dac_pend  <= dac_busy;
    end else if (r_dac_pend && !dac_busy) begin
      r_dac_valid <= 1'b1;
      r_dac_pend  <= 1'b0;
    end else begin
      r_dac_valid <= 1'b0;
    end
  end

  always_ff @(posedge DCLK) begin
    if (rst)                               r_overrun <= 1'b0;
    else if (trig && (r_state == CAPTURE)) r_overrun <= 1'b1;
  end

  assign rd_grant = rd_req && (r_state == IDLE) && !trig;

  always_ff @(posedge DCLK) begin
    if (rst) r_rd_valid <= 1'b0;
    else     r_rd_valid <= rd_grant;
  end

  assign mem_addr  = wr_en ? r_wr_addr : rd_addr;
  assign rd_valid  = r_rd_valid;
  assign PHV       = r_phv;
  assign PnHV      = r_pnhv;
  assign Pdamp     = r_pdamp;
  assign dac_code  = r_dac_code;
  assign dac_valid = r_dac_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: each shot's expected events are predicted
// at trigger time and consumed by a monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_acq_sequencer;

  localparam int AW  = 13;
  localparam int TW  = 10;
  localparam int N   = 1 << AW;
  localparam int BIG = 1 << 30;

  logic          DCLK = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic [7:0]    phv_start = '0, phv_end = '0, pnhv_start = '0, pnhv_end = '0;
  logic [7:0]    damp_start = '0, damp_end = '0;
  logic [TW-1:0] tgc_start = '0;
  logic [7:0]    tgc_slope = '0, tgc_interval = '0;
  logic          dac_busy = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_en, rd_grant, rd_valid, PHV, PnHV, Pdamp, dac_valid, busy, done, overrun;
  logic [AW-1:0] mem_addr;
  logic [TW-1:0] dac_code;

  acq_sequencer #(.ADDR_W(AW), .TGC_W(TW)) dut (
    .DCLK(DCLK), .rst(rst), .trig(trig),
    .phv_start(phv_start), .phv_end(phv_end),
    .pnhv_start(pnhv_start), .pnhv_end(pnhv_end),
    .damp_start(damp_start), .damp_end(damp_end),
    .tgc_start(tgc_start), .tgc_slope(tgc_slope), .tgc_interval(tgc_interval),
    .dac_busy(dac_busy), .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_en(wr_en), .mem_addr(mem_addr), .rd_grant(rd_grant), .rd_valid(rd_valid),
    .PHV(PHV), .PnHV(PnHV), .Pdamp(Pdamp),
    .dac_code(dac_code), .dac_valid(dac_valid),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 DCLK = ~DCLK;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  bit bsy_plan [0:65535];
  int q_wr[$], q_done[$], q_phv[$], q_pnhv[$], q_pdamp[$], q_dac_cyc[$], q_dac_code[$];
  int m_T = 0, m_cut = BIG, ovr_from = BIG, ovr_to = BIG, final_code = 0;
  bit m_valid = 0, mon_en = 0;

  always @(posedge DCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic pop_edge(input string name, input int id);
    int  exp;
    bit  ok;
    ok  = 1'b1;
    exp = 0;
    case (id)
      0: if (q_wr.size() > 0)    exp = q_wr.pop_front();    else ok = 1'b0;
      1: if (q_done.size() > 0)  exp = q_done.pop_front();  else ok = 1'b0;
      2: if (q_phv.size() > 0)   exp = q_phv.pop_front();   else ok = 1'b0;
      3: if (q_pnhv.size() > 0)  exp = q_pnhv.pop_front();  else ok = 1'b0;
      default: if (q_pdamp.size() > 0) exp = q_pdamp.pop_front(); else ok = 1'b0;
    endcase
    if (ok) chk(name, cyc, exp);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL %s cycle %0d: got an edge, expected none", name, cyc);
    end
  endtask

  // Reference model: shot starts at cycle T (first wr_en cycle); cut is the
  // first cycle after a mid-shot reset (BIG when the shot runs to completion).
  task automatic predict(input int T, input int cut);
    int  s, e, r, f, code, nc;
    bit  pend, chg;
    q_wr.push_back(T);
    q_wr.push_back((T + N < cut) ? T + N : cut);
    if (T + N < cut) q_done.push_back(T + N);
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: begin s = int'(phv_start);  e = int'(phv_end);  end
        1: begin s = int'(pnhv_start); e = int'(pnhv_end); end
        default: begin s = int'(damp_start); e = int'(damp_end); end
      endcase
      if (s < e) begin
        r = T + s + 1;
        f = T + e + 1;
        if (f > cut) f = cut;
        if (r < f) begin
          case (p)
            0: begin q_phv.push_back(r);   q_phv.push_back(f);   end
            1: begin q_pnhv.push_back(r);  q_pnhv.push_back(f);  end
            default: begin q_pdamp.push_back(r); q_pdamp.push_back(f); end
          endcase
        end
      end
    end
    code = int'(tgc_start);
    pend = 1'b0;
    for (int E = T; E <= T + N + 4 && E < cut; E++) begin
      chg = (E == T);
      if (!chg && tgc_interval != 0 && E <= T + N && ((E - T) % int'(tgc_interval)) == 0) begin
        nc = code + int'(tgc_slope);
        if (nc > (1 << TW) - 1) nc = (1 << TW) - 1;
        if (nc != code) begin code = nc; chg = 1'b1; end
      end
      if ((chg || pend) && !bsy_plan[E-1]) begin
        q_dac_cyc.push_back(E);
        q_dac_code.push_back(code);
        pend = 1'b0;
      end else if (chg) begin
        pend = 1'b1;
      end
    end
    final_code = (cut < BIG) ? 0 : code;
  endtask

  always @(negedge DCLK) begin : monitor
    bit cap, fin, eg;
    logic p_wr, p_phv, p_pnhv, p_pdamp;
    bit p_grant, p_rst;
    cap = m_valid && cyc >= m_T && cyc < m_T + N && cyc < m_cut;
    fin = m_valid && cyc == m_T + N && cyc < m_cut;
    eg  = rd_req && !cap && !fin && !trig;
    if (mon_en) begin
      chk("mem_addr", int'(mem_addr), cap ? cyc - m_T : int'(rd_addr));
      chk("busy", int'(busy), int'(cap));
      chk("rd_grant", int'(rd_grant), int'(eg));
      chk("rd_valid", int'(rd_valid), int'(p_grant && !p_rst));
      chk("overrun", int'(overrun), int'(cyc >= ovr_from && cyc < ovr_to));
      if (wr_en !== p_wr)   pop_edge("wr_en_edge", 0);
      if (done)             pop_edge("done", 1);
      if (PHV !== p_phv)    pop_edge("PHV_edge", 2);
      if (PnHV !== p_pnhv)  pop_edge("PnHV_edge", 3);
      if (Pdamp !== p_pdamp) pop_edge("Pdamp_edge", 4);
      if (dac_valid) begin
        if (q_dac_cyc.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dac_valid cycle %0d: got strobe code %0d, expected none", cyc, dac_code);
        end else begin
          chk("dac_valid_cycle", cyc, q_dac_cyc.pop_front());
          chk("dac_code", int'(dac_code), q_dac_code.pop_front());
        end
      end
    end
    p_wr = wr_en; p_phv = PHV; p_pnhv = PnHV; p_pdamp = Pdamp;
    p_grant = eg; p_rst = rst;
  end

  task automatic step();
    @(posedge DCLK);
    #1;
    dac_busy = bsy_plan[cyc];
  endtask

  task automatic fill_busy(input int from, input int to, input int mode);
    int len;
    bit lvl;
    len = 0;
    lvl = 1'b0;
    for (int c = from; c <= to; c++) begin
      if (mode == 1) begin
        if (len == 0) begin
          len = $urandom_range(1, 40);
          lvl = ($urandom_range(0, 9) < 3);
        end
        len--;
        bsy_plan[c] = lvl;
      end else begin
        bsy_plan[c] = 1'b0;
      end
    end
    if (mode == 2) for (int c = from + 16; c <= from + 46; c++) bsy_plan[c] = 1'b1;
  endtask

  task automatic rand_cfg();
    phv_start  = 8'($urandom); phv_end  = 8'($urandom);
    pnhv_start = 8'($urandom); pnhv_end = 8'($urandom);
    damp_start = 8'($urandom); damp_end = 8'($urandom);
    tgc_start  = TW'($urandom);
    tgc_slope  = 8'($urandom);
    case ($urandom_range(0, 4))
      0:       tgc_interval = 8'd0;
      1:       tgc_interval = 8'd1;
      default: tgc_interval = 8'($urandom_range(2, 255));
    endcase
  endtask

  task automatic shot(input int bmode, input int ovr_at, input int rst_at, input bit rd_rand);
    int T, cut, len;
    T = cyc + 2;
    fill_busy(T - 1, T + N - 1, bmode);
    step();
    trig = 1'b1;
    cut  = (rst_at >= 0) ? T + rst_at + 1 : BIG;
    predict(T, cut);
    m_T = T; m_cut = cut; m_valid = 1'b1;
    len = (rst_at >= 0) ? rst_at + 40 : N + 10;
    for (int i = 0; i < len; i++) begin
      step();
      trig = (ovr_at >= 0) && (cyc == T + ovr_at);
      rst  = (rst_at >= 0) && (cyc == T + rst_at);
      if (trig && !(cyc >= ovr_from && cyc < ovr_to)) ovr_from = cyc + 1;
      if (rst) ovr_to = cyc + 1;
      if (rd_rand) begin
        rd_req  = 1'($urandom_range(0, 1));
        rd_addr = AW'($urandom);
      end
    end
    chk("final_dac_code", int'(dac_code), final_code);
  endtask

  initial begin
    rd_addr = 13'h123;
    repeat (3) step();
    rst = 1'b0;
    @(negedge DCLK);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_dac_code", int'(dac_code), 0);
    chk("rst_dac_valid", int'(dac_valid), 0);
    chk("rst_pulsers", int'({PHV, PnHV, Pdamp}), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_mem_addr", int'(mem_addr), 'h123);
    mon_en = 1'b1;
    step();

    // Directed shot: reference windows, saturating ramp, reader held off by capture.
    phv_start = 8'd32;  phv_end = 8'd40;
    pnhv_start = 8'd48; pnhv_end = 8'd56;
    damp_start = 8'd64; damp_end = 8'd128;
    tgc_start = TW'(100); tgc_slope = 8'd200; tgc_interval = 8'd250;
    rd_req = 1'b1; rd_addr = AW'(5);
    shot(0, -1, -1, 1'b0);
    rd_req = 1'b0;

    // DAC busy across two steps; empty and inverted windows.
    phv_start = 8'd50;   phv_end = 8'd50;
    pnhv_start = 8'd200; pnhv_end = 8'd10;
    damp_start = 8'd0;   damp_end = 8'd255;
    tgc_start = TW'(100); tgc_slope = 8'd10; tgc_interval = 8'd20;
    shot(2, -1, -1, 1'b1);

    rand_cfg();
    shot(1, 100, -1, 1'b1);

    rand_cfg();
    phv_start = 8'd40; phv_end = 8'd60;
    pnhv_start = 8'd45; pnhv_end = 8'd200;
    damp_start = 8'd0; damp_end = 8'd51;
    shot(1, -1, 50, 1'b1);

    rand_cfg();
    shot(1, -1, -1, 1'b1);
    repeat (5) step();

    chk("left_wr_edges", q_wr.size(), 0);
    chk("left_done", q_done.size(), 0);
    chk("left_phv", q_phv.size(), 0);
    chk("left_pnhv", q_pnhv.size(), 0);
    chk("left_pdamp", q_pdamp.size(), 0);
    chk("left_dac", q_dac_cyc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
